// File: rtl/rob_commit_unit_pkg.sv
// Shared ROB constants and entry layout, also used by the reservation station.
package RSTableROBStruct;
  localparam int ROB_ROW_COUNT = 64;
  localparam int TAG_W         = $clog2(ROB_ROW_COUNT);
  localparam int COUNT_W       = TAG_W + 1;
  localparam int PREG_COUNT    = 64;
  localparam int PREG_W        = $clog2(PREG_COUNT);
  localparam int FU_COUNT      = 3;
  localparam int DATA_W        = 32;

  typedef logic [TAG_W-1:0]  rob_tag_t;
  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    logic              used;
    preg_t             p_rd;
    preg_t             p_old_rd;
    logic              is_sw;
    logic              completed;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

  // Tags wrap naturally at TAG_W bits, so storage index and tag stay identical.
  function automatic rob_tag_t tag_add(rob_tag_t t, rob_tag_t n);
    return t + n;
  endfunction
endpackage

// File: rtl/rob_commit_unit_if.sv
// Dispatch, completion and commit bundle of the reorder buffer.
// slave = ROB side, master = core side.
interface rob_commit_unit_if;
  import RSTableROBStruct::*;

  // Dispatch handshake: a slot is consumed on a rising edge only when alloc_ready and
  // alloc_valid[n] are both high; slot 1 is taken only together with slot 0, and
  // dispatch must hold its request while alloc_ready is low.
  logic [1:0]            alloc_valid;
  preg_t                 alloc_p_rd     [2];
  preg_t                 alloc_p_old_rd [2];
  logic [1:0]            alloc_is_sw;
  logic                  alloc_ready;
  rob_tag_t              alloc_tag      [2];

  logic [FU_COUNT-1:0]   fu_done;
  rob_tag_t              fu_tag         [FU_COUNT];
  logic [DATA_W-1:0]     fu_out         [FU_COUNT];

  logic [FU_COUNT-1:0]   wb_valid;
  preg_t                 wb_preg        [FU_COUNT];
  logic [DATA_W-1:0]     wb_data        [FU_COUNT];
  logic [PREG_COUNT-1:0] ready_set;

  logic [1:0]            retire_valid;
  preg_t                 retire_p_rd     [2];
  preg_t                 retire_p_old_rd [2];
  logic [1:0]            retire_is_sw;
  logic [DATA_W-1:0]     retire_data     [2];
  logic [COUNT_W-1:0]    rob_count;

  modport master (
    output alloc_valid, alloc_p_rd, alloc_p_old_rd, alloc_is_sw,
    output fu_done, fu_tag, fu_out,
    input  alloc_ready, alloc_tag, wb_valid, wb_preg, wb_data, ready_set,
    input  retire_valid, retire_p_rd, retire_p_old_rd, retire_is_sw, retire_data, rob_count
  );

  modport slave (
    input  alloc_valid, alloc_p_rd, alloc_p_old_rd, alloc_is_sw,
    input  fu_done, fu_tag, fu_out,
    output alloc_ready, alloc_tag, wb_valid, wb_preg, wb_data, ready_set,
    output retire_valid, retire_p_rd, retire_p_old_rd, retire_is_sw, retire_data, rob_count
  );
endinterface

// File: rtl/rob_retire_select.sv
// Picks how many entries retire this edge: head alone, or head and head+1, in order.
module rob_retire_select (
  input  logic       i_head_used,
  input  logic       i_head_completed,
  input  logic       i_next_used,
  input  logic       i_next_completed,
  output logic [1:0] o_retire
);
  always_comb begin
    o_retire    = '0;
    o_retire[0] = i_head_used && i_head_completed;
    o_retire[1] = o_retire[0] && i_next_used && i_next_completed;
  end
endmodule

// File: rtl/rob_commit_unit.sv
// Reorder buffer: in-order dual allocation, tag-addressed completion with writeback
// broadcast, and in-order retirement of up to two entries per cycle.
module rob_commit_unit
  import RSTableROBStruct::*;
(
  input  logic             clk,
  input  logic             rst,
  rob_commit_unit_if.slave bus
);
  rob_entry_t            r_rob [ROB_ROW_COUNT];
  rob_tag_t              r_head;
  rob_tag_t              r_tail;
  logic [COUNT_W-1:0]    r_count;

  logic [FU_COUNT-1:0]   r_wb_valid;
  preg_t                 r_wb_preg [FU_COUNT];
  logic [DATA_W-1:0]     r_wb_data [FU_COUNT];
  logic [PREG_COUNT-1:0] r_ready_set;
  logic [1:0]            r_ret_valid;
  preg_t                 r_ret_p_rd     [2];
  preg_t                 r_ret_p_old_rd [2];
  logic [1:0]            r_ret_is_sw;
  logic [DATA_W-1:0]     r_ret_data     [2];

  logic                  w_alloc_ready;
  logic                  w_alloc0;
  logic                  w_alloc1;
  logic [1:0]            w_n_alloc;
  logic [1:0]            w_n_retire;
  logic [1:0]            w_retire;
  rob_tag_t              w_head1;
  rob_tag_t              w_tail1;
  logic [FU_COUNT-1:0]   w_hit;
  logic [FU_COUNT-1:0]   w_wb;
  logic [PREG_COUNT-1:0] w_ready_set;
  rob_entry_t            w_ret_entry [2];

  assign w_head1       = tag_add(r_head, rob_tag_t'(1));
  assign w_tail1       = tag_add(r_tail, rob_tag_t'(1));
  // No credit for a same-cycle retire: readiness looks at the current count only.
  assign w_alloc_ready = !rst && (r_count <= COUNT_W'(ROB_ROW_COUNT - 2));
  assign w_alloc0      = w_alloc_ready && bus.alloc_valid[0];
  assign w_alloc1      = w_alloc0 && bus.alloc_valid[1];
  assign w_n_alloc     = {1'b0, w_alloc0} + {1'b0, w_alloc1};
  assign w_n_retire    = {1'b0, w_retire[0]} + {1'b0, w_retire[1]};
  assign w_ret_entry[0] = r_rob[r_head];
  assign w_ret_entry[1] = r_rob[w_head1];

  rob_retire_select u_retire_select (
    .i_head_used      (r_rob[r_head].used),
    .i_head_completed (r_rob[r_head].completed),
    .i_next_used      (r_rob[w_head1].used),
    .i_next_completed (r_rob[w_head1].completed),
    .o_retire         (w_retire)
  );

  // A result counts only against a live, pending entry; on a duplicate tag the lowest FU wins.
  always_comb begin
    w_hit       = '0;
    w_wb        = '0;
    w_ready_set = '0;
    for (int i = 0; i < FU_COUNT; i++) begin
      w_hit[i] = bus.fu_done[i] && r_rob[bus.fu_tag[i]].used && !r_rob[bus.fu_tag[i]].completed;
      for (int j = 0; j < i; j++) begin
        if (bus.fu_done[j] && (bus.fu_tag[j] == bus.fu_tag[i])) w_hit[i] = 1'b0;
      end
      w_wb[i] = w_hit[i] && !r_rob[bus.fu_tag[i]].is_sw && (r_rob[bus.fu_tag[i]].p_rd != '0);
      if (w_wb[i]) w_ready_set[r_rob[bus.fu_tag[i]].p_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < ROB_ROW_COUNT; k++) r_rob[k] <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_wb_valid  <= '0;
      r_ready_set <= '0;
      r_ret_valid <= '0;
      r_ret_is_sw <= '0;
      for (int i = 0; i < FU_COUNT; i++) begin
        r_wb_preg[i] <= '0;
        r_wb_data[i] <= '0;
      end
      for (int s = 0; s < 2; s++) begin
        r_ret_p_rd[s]     <= '0;
        r_ret_p_old_rd[s] <= '0;
        r_ret_data[s]     <= '0;
      end
    end else begin
      // Retire, complete and allocate never touch the same entry in one edge.
      if (w_retire[0]) r_rob[r_head]  <= '0;
      if (w_retire[1]) r_rob[w_head1] <= '0;
      for (int i = 0; i < FU_COUNT; i++) begin
        if (w_hit[i]) begin
          r_rob[bus.fu_tag[i]].completed <= 1'b1;
          r_rob[bus.fu_tag[i]].data      <= bus.fu_out[i];
        end
      end
      if (w_alloc0) r_rob[r_tail] <= '{used: 1'b1, p_rd: bus.alloc_p_rd[0],
                                       p_old_rd: bus.alloc_p_old_rd[0], is_sw: bus.alloc_is_sw[0],
                                       completed: 1'b0, data: '0};
      if (w_alloc1) r_rob[w_tail1] <= '{used: 1'b1, p_rd: bus.alloc_p_rd[1],
                                        p_old_rd: bus.alloc_p_old_rd[1], is_sw: bus.alloc_is_sw[1],
                                        completed: 1'b0, data: '0};
      r_head  <= r_head + TAG_W'(w_n_retire);
      r_tail  <= r_tail + TAG_W'(w_n_alloc);
      r_count <= r_count + COUNT_W'(w_n_alloc) - COUNT_W'(w_n_retire);

      r_wb_valid  <= w_wb;
      r_ready_set <= w_ready_set;
      for (int i = 0; i < FU_COUNT; i++) begin
        r_wb_preg[i] <= w_wb[i] ? r_rob[bus.fu_tag[i]].p_rd : '0;
        r_wb_data[i] <= w_wb[i] ? bus.fu_out[i] : '0;
      end

      r_ret_valid <= w_retire;
      for (int s = 0; s < 2; s++) begin
        r_ret_is_sw[s]    <= w_retire[s] && w_ret_entry[s].is_sw;
        r_ret_p_rd[s]     <= w_retire[s] ? w_ret_entry[s].p_rd     : '0;
        r_ret_p_old_rd[s] <= w_retire[s] ? w_ret_entry[s].p_old_rd : '0;
        r_ret_data[s]     <= w_retire[s] ? w_ret_entry[s].data     : '0;
      end
    end
  end

  assign bus.alloc_ready     = w_alloc_ready;
  assign bus.alloc_tag[0]    = r_tail;
  assign bus.alloc_tag[1]    = w_tail1;
  assign bus.wb_valid        = r_wb_valid;
  assign bus.wb_preg         = r_wb_preg;
  assign bus.wb_data         = r_wb_data;
  assign bus.ready_set       = r_ready_set;
  assign bus.retire_valid    = r_ret_valid;
  assign bus.retire_p_rd     = r_ret_p_rd;
  assign bus.retire_p_old_rd = r_ret_p_old_rd;
  assign bus.retire_is_sw    = r_ret_is_sw;
  assign bus.retire_data     = r_ret_data;
  assign bus.rob_count       = r_count;
endmodule

// File: doc/rob_commit_unit.md
# rob_commit_unit

Reorder buffer and completion/commit engine at the back end of the out-of-order core. It allocates entries in program order from dual-issue dispatch and accepts results from the three functional units by ROB tag. It broadcasts those results to the dirty register file and ready table, and retires up to two completed instructions per cycle in order, releasing old physical registers to the free list.

## Interface
- ROB_ROW_COUNT, 64: ROB entries; power of two; tag width log2 = 6.
- PREG_COUNT, 64: physical registers; preg 0 is hardwired zero.
- FU_COUNT, 3: completion ports (FU0/FU1 ALU, FU2 load/store).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- alloc_valid  in  2  dispatch slot requests; bit1 honoured only with bit0.
- alloc_p_rd[0:1]  in  6  destination physical register per slot.
- alloc_p_old_rd[0:1]  in  6  previous mapping of the architectural rd.
- alloc_is_sw  in  2  slot is a store (no register writeback).
- alloc_ready  out  1  combinational; 1 when count <= ROB_ROW_COUNT-2 and rst low.
- alloc_tag[0:1]  out  6  combinational; tail and tail+1 (mod 64).
- fu_done  in  3  FU i result valid this cycle.
- fu_tag[0:2]  in  6  ROB tag of FU i result.
- fu_out[0:2]  in  32  FU i result data.
- wb_valid  out  3  registered writeback strobe per FU.
- wb_preg[0:2]  out  6  physical register written.
- wb_data[0:2]  out  32  value written.
- ready_set  out  64  registered one-cycle pulse vector of pregs becoming ready.
- retire_valid  out  2  registered; bit1 only with bit0.
- retire_p_rd[0:1], retire_p_old_rd[0:1]  out  6  retired mapping / preg to free.
- retire_is_sw  out  2  retiring store (commit store to memory).
- retire_data[0:1]  out  32  result stored in entry.
- rob_count  out  7  occupied entries, 0..64.

## Operation
- Entry fields: used, p_rd, p_old_rd, is_sw, completed, data.
- Allocate: if alloc_ready and alloc_valid[0], entry at tail written (used=1, completed=0); with alloc_valid[1] also tail+1. Tail advances by 1 or 2. alloc_valid with alloc_ready low is ignored (dispatch must stall).
- Complete: for each fu_done[i] whose tag hits a used, not-completed entry: store fu_out, set completed. If entry not sw and p_rd != 0: wb_valid[i]=1, wb_preg/wb_data driven, ready_set[p_rd]=1 next cycle. Hits on unused or already-completed entries are dropped with no writeback. Two FUs with the same tag in one cycle is illegal; lowest index wins.
- Retire: at each edge, if head entry used and completed, retire it; if also head+1 used and completed, retire both. Never retire head+1 without head. Retired entries cleared; head advances mod 64.
- count_next = count + allocs - retires; simultaneous alloc and retire in one cycle are both applied; alloc_ready uses current count only (no credit for same-cycle retire).
- Full (count=64): alloc_ready=0. Empty: retire_valid=0.

## Timing
- Reset (async assert, sync-visible deassert): head=tail=count=0, all used/completed cleared; wb_valid, ready_set, retire_valid, all data/tag outputs 0; alloc_ready=0 while rst high. Reset mid-operation discards all entries.
- Allocate at edge N: entry visible at N; completion for it may arrive at edge N+1 earliest.
- fu_done sampled at edge N: wb_* and ready_set valid cycle after N (1-cycle latency).
- Completed at edge N: earliest retire at edge N+1, retire_* valid cycle after N+1.
- Completion and retire of the same entry are never in the same edge.
- Pointer wrap: tag 63 followed by tag 0; tail+1 computed modulo 64 for both tag and storage.

## Structure
- Entry struct typedef, FU_COUNT, tag width and ROB_ROW_COUNT constants belong in package RSTableROBStruct, shared with the reservation station.
- Sub-module rob_retire_select: combinational picker of 0/1/2 retiring entries from head state.

## Test plan
- Reset, alloc both slots (p_rd 5,6; old 1,2) -> alloc_tag 0,1, rob_count 2; fu_done FU0 tag 1 data 0xAA -> wb_preg 6, ready_set bit 6, no retire until tag 0 completes.
- Then FU1 tag 0 data 0x55 -> next edge retire_valid=2'b11, retire_p_old_rd 1,2, rob_count 0.
- Fill 64 entries -> alloc_ready=0 at count 64; retire 2 -> alloc_ready=1; tags wrap 63->0.
- Store entry with p_rd 9 completes -> no wb_valid, no ready_set; retire_is_sw=1 with data.
- Three fu_done same cycle, tags 3,4,5 with p_rd 0 on tag 4 -> wb_valid=3'b101.
- Assert rst with 10 entries in flight -> all outputs 0 immediately, rob_count 0, alloc_tag 0 after release.
